// File: rtl/isp_timed_bus_if.sv
// ---------------------------------------------------------------------------
// isp_timed_bus_if
// Bridges an Avalon-MM slave onto an asynchronous chip-select/strobe bus with
// fixed, parameterised setup / strobe / hold / turnaround timing, and
// synchronises the two external interrupt lines into the clock domain.
//
// Ports
//   csi_clk, csi_reset_n      : clock, synchronous active-low reset
//   avs_address/read/write/
//   writedata/readdata/
//   waitrequest               : Avalon-MM slave
//   ins_hc_irq, ins_dc_irq    : synchronised interrupts
//   CS_N, RD_N, WR_N, A       : external bus control and byte address
//   D_IN, D_OUT, D_OE         : split external data bus (tristate built above)
//   HC_IRQ, DC_IRQ            : raw external interrupts
//   HC_DACK, DC_DACK          : DMA acknowledges, permanently inactive (high)
// ---------------------------------------------------------------------------
module isp_timed_bus_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 2,
    parameter int T_TURN   = 1
) (
    input  logic              csi_clk,
    input  logic              csi_reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic              ins_hc_irq,
    output logic              ins_dc_irq,
    output logic              CS_N,
    output logic              RD_N,
    output logic              WR_N,
    output logic [ADDR_W:0]   A,
    input  logic [DATA_W-1:0] D_IN,
    output logic [DATA_W-1:0] D_OUT,
    output logic              D_OE,
    input  logic              HC_IRQ,
    input  logic              DC_IRQ,
    output logic              DC_DACK,
    output logic              HC_DACK
);

    localparam int T_MAX_A = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int T_MAX_B = (T_HOLD > T_TURN) ? T_HOLD : T_TURN;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    // The counter holds "remaining cycles minus one", so T_MAX-1 is its peak.
    localparam int CNT_W   = (T_MAX < 2) ? 1 : $clog2(T_MAX);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'((T_TURN > 0) ? (T_TURN - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              d_oe_q, d_oe_d;
    logic              last_q, last_d;
    logic              hc_s1_q, hc_s2_q, dc_s1_q, dc_s2_q;
    logic              req_s, start_s, active_s;

    assign req_s = avs_read | avs_write;

    // Next-state, counter, latched request and registered bus outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        start_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    start_s = 1'b1;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    // Capture on the edge that closes the last strobe cycle.
                    if (!wr_q) begin
                        rdata_d = D_IN;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    if (T_TURN == 0) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_TURN: begin
                if (cnt_q == CNT_ZERO) begin
                    // A request held off during turnaround starts straight
                    // away so only T_TURN idle cycles separate the accesses.
                    if (req_s) begin
                        start_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        if (start_s) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            addr_d  = avs_address;
            wr_d    = avs_write & ~avs_read;   // read wins when both asserted
            wdata_d = avs_writedata;
        end else begin
            wr_d = wr_d;
        end

        active_s = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);

        // With no turnaround, chip select stays asserted through the idle
        // cycle after HOLD so a queued access follows without CS_N toggling.
        if ((state_q == ST_HOLD) && (state_d == ST_IDLE)) begin
            cs_n_d = 1'b0;
        end else begin
            cs_n_d = ~active_s;
        end

        rd_n_d = ~((state_d == ST_STROBE) && !wr_d);
        wr_n_d = ~((state_d == ST_STROBE) && wr_d);
        d_oe_d = active_s & wr_d;
        last_d = (state_d == ST_HOLD) && (cnt_d == CNT_ZERO);
    end

    // State, counter, request latch and output registers.
    always_ff @(posedge csi_clk) begin
        if (!csi_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            d_oe_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            d_oe_q  <= d_oe_d;
            last_q  <= last_d;
        end
    end

    // Two-flop interrupt synchronisers.
    always_ff @(posedge csi_clk) begin
        if (!csi_reset_n) begin
            hc_s1_q <= 1'b0;
            hc_s2_q <= 1'b0;
            dc_s1_q <= 1'b0;
            dc_s2_q <= 1'b0;
        end else begin
            hc_s1_q <= HC_IRQ;
            hc_s2_q <= hc_s1_q;
            dc_s1_q <= DC_IRQ;
            dc_s2_q <= dc_s1_q;
        end
    end

    // Stall every requested cycle except the final HOLD cycle; idle, or held
    // in reset, the slave never stalls.
    assign avs_waitrequest = req_s & ~last_q & csi_reset_n;
    assign avs_readdata    = rdata_q;
    assign CS_N            = cs_n_q;
    assign RD_N            = rd_n_q;
    assign WR_N            = wr_n_q;
    assign A               = {addr_q, 1'b0};
    assign D_OUT           = wdata_q;
    assign D_OE            = d_oe_q;
    assign ins_hc_irq      = hc_s2_q;
    assign ins_dc_irq      = dc_s2_q;
    assign HC_DACK         = 1'b1;
    assign DC_DACK         = 1'b1;

endmodule

// File: tb/tb_isp_timed_bus_if.sv
// ---------------------------------------------------------------------------
// Bench for isp_timed_bus_if. Instance 0 uses default timing (32-bit data);
// instance 1 uses 1/1/1/0 timing with 16-bit data. The bench plays both the
// Avalon master and a simple external memory device; a reference memory
// holds what every completed Avalon write should have left behind.
// ---------------------------------------------------------------------------
module tb_isp_timed_bus_if;

    logic clk;
    logic rst_n;
    logic [15:0] addr_i [2];
    logic        rd_i   [2];
    logic        wr_i   [2];
    logic [31:0] wd_i   [2];
    logic [31:0] din    [2];
    logic        hc_in, dc_in;

    wire [31:0] rdata_o [2];
    wire        wait_o  [2];
    wire        hc_o    [2];
    wire        dc_o    [2];
    wire        cs_n    [2];
    wire        rd_n    [2];
    wire        wr_n    [2];
    wire [16:0] a_o     [2];
    wire [31:0] dout    [2];
    wire        oe      [2];
    wire        hdack   [2];
    wire        ddack   [2];
    wire [15:0] b_rdata, b_dout;

    assign rdata_o[1] = {16'd0, b_rdata};
    assign dout[1]    = {16'd0, b_dout};

    int TS  [2] = '{2, 1};
    int TST [2] = '{4, 1};
    int TH  [2] = '{2, 1};
    logic [31:0] DMASK [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};

    int checks   = 0;
    int failures = 0;

    logic [31:0] dev_mem [int];
    logic [31:0] ref_mem [int];

    logic        o_cs, o_rd, o_wr, o_oe, o_wait;
    logic [16:0] o_a;
    logic [31:0] o_dout;
    logic        first_cs;

    isp_timed_bus_if u_dut0 (
        .csi_clk(clk), .csi_reset_n(rst_n),
        .avs_address(addr_i[0]), .avs_read(rd_i[0]), .avs_write(wr_i[0]),
        .avs_writedata(wd_i[0]), .avs_readdata(rdata_o[0]), .avs_waitrequest(wait_o[0]),
        .ins_hc_irq(hc_o[0]), .ins_dc_irq(dc_o[0]),
        .CS_N(cs_n[0]), .RD_N(rd_n[0]), .WR_N(wr_n[0]), .A(a_o[0]),
        .D_IN(din[0]), .D_OUT(dout[0]), .D_OE(oe[0]),
        .HC_IRQ(hc_in), .DC_IRQ(dc_in), .DC_DACK(ddack[0]), .HC_DACK(hdack[0])
    );

    isp_timed_bus_if #(.DATA_W(16), .ADDR_W(16), .T_SETUP(1), .T_STROBE(1),
                       .T_HOLD(1), .T_TURN(0)) u_dut1 (
        .csi_clk(clk), .csi_reset_n(rst_n),
        .avs_address(addr_i[1]), .avs_read(rd_i[1]), .avs_write(wr_i[1]),
        .avs_writedata(wd_i[1][15:0]), .avs_readdata(b_rdata), .avs_waitrequest(wait_o[1]),
        .ins_hc_irq(hc_o[1]), .ins_dc_irq(dc_o[1]),
        .CS_N(cs_n[1]), .RD_N(rd_n[1]), .WR_N(wr_n[1]), .A(a_o[1]),
        .D_IN(din[1][15:0]), .D_OUT(b_dout), .D_OE(oe[1]),
        .HC_IRQ(hc_in), .DC_IRQ(dc_in), .DC_DACK(ddack[1]), .HC_DACK(hdack[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Content of a never-written device location.
    function automatic logic [31:0] def_val(input int key);
        logic [31:0] v;
        v = (32'(key) * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
        return (key >= 65536) ? (v & 32'h0000_FFFF) : v;
    endfunction

    function automatic logic [31:0] dev_lookup(input int key);
        return dev_mem.exists(key) ? dev_mem[key] : def_val(key);
    endfunction

    // One bus cycle: sample at negedge (device latches writes), then step past
    // the next posedge and present read data for the current address.
    task automatic cyc(input int s);
        int key;
        @(negedge clk);
        o_cs = cs_n[s]; o_rd = rd_n[s]; o_wr = wr_n[s]; o_oe = oe[s];
        o_wait = wait_o[s]; o_a = a_o[s]; o_dout = dout[s];
        key = s * 65536 + int'(a_o[s][16:1]);
        if (!cs_n[s] && !wr_n[s] && oe[s]) dev_mem[key] = dout[s] & DMASK[s];
        @(posedge clk);
        #1;
        key = s * 65536 + int'(a_o[s][16:1]);
        din[s] = dev_lookup(key);
    endtask

    // One Avalon access, checked cycle by cycle against the timing rules.
    task automatic run_access(input int s, input bit r, input bit w,
                              input logic [15:0] ad, input logic [31:0] wd);
        int L, lat, n_oe, key;
        bit done, wr_only, in_strobe;
        logic [2:0] exp_v;
        logic [31:0] exp_rd;
        L = TS[s] + TST[s] + TH[s];
        wr_only = w && !r;
        key = s * 65536 + int'(ad);
        addr_i[s] = ad; wd_i[s] = wd; rd_i[s] = r; wr_i[s] = w;
        done = 1'b0; lat = -1; n_oe = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            cyc(s);
            if (k == 0) first_cs = o_cs;
            if (o_oe === 1'b1) n_oe++;
            in_strobe = (k > TS[s]) && (k <= TS[s] + TST[s]);
            exp_v = {!(r && in_strobe), !(wr_only && in_strobe), wr_only && (k >= 1) && (k <= L)};
            checks++;
            if ({o_rd, o_wr, o_oe} !== exp_v)
                begin failures++; $display("FAIL strobes s=%0d k=%0d got={rd,wr,oe}=%b exp=%b", s, k, {o_rd, o_wr, o_oe}, exp_v); end
            if (k >= 1 && k <= L) begin
                checks++;
                if ({o_cs, o_a} !== {1'b0, ad, 1'b0})
                    begin failures++; $display("FAIL cs_addr s=%0d k=%0d got=%b_%h exp=0_%h", s, k, o_cs, o_a, {ad, 1'b0}); end
            end else if (k == 0 && s == 0) begin
                checks++;
                if (o_cs !== 1'b1)
                    begin failures++; $display("FAIL cs_pre s=%0d got=%b exp=1", s, o_cs); end
            end
            if (o_oe === 1'b1) begin
                checks++;
                if (o_dout !== (wd & DMASK[s]))
                    begin failures++; $display("FAIL d_out s=%0d k=%0d got=%h exp=%h", s, k, o_dout, wd & DMASK[s]); end
            end
            if (o_wait === 1'b0) begin done = 1'b1; lat = k; end
        end
        rd_i[s] = 1'b0; wr_i[s] = 1'b0;
        checks++;
        if (lat != L) begin failures++; $display("FAIL latency s=%0d got=%0d exp=%0d", s, lat, L); end
        checks++;
        if (n_oe != (wr_only ? L : 0))
            begin failures++; $display("FAIL oe_count s=%0d got=%0d exp=%0d", s, n_oe, wr_only ? L : 0); end
        if (r) begin
            exp_rd = ref_mem.exists(key) ? ref_mem[key] : def_val(key);
            checks++;
            if (rdata_o[s] !== exp_rd)
                begin failures++; $display("FAIL readdata s=%0d addr=%h got=%h exp=%h", s, ad, rdata_o[s], exp_rd); end
        end else if (w) begin
            ref_mem[key] = wd & DMASK[s];
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({cs_n[s], rd_n[s], wr_n[s], oe[s], wait_o[s], hc_o[s], dc_o[s], hdack[s], ddack[s]} !== 9'b111_00_00_11)
                begin failures++; $display("FAIL reset_ctl s=%0d got=%b exp=111000011", s,
                      {cs_n[s], rd_n[s], wr_n[s], oe[s], wait_o[s], hc_o[s], dc_o[s], hdack[s], ddack[s]}); end
            checks++;
            if (rdata_o[s] !== 32'h0) begin failures++; $display("FAIL reset_rdata s=%0d got=%h exp=0", s, rdata_o[s]); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({wait_o[s], cs_n[s]} !== 2'b01)
                begin failures++; $display("FAIL idle_wait s=%0d got={wait,cs}=%b exp=01", s, {wait_o[s], cs_n[s]}); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read_default;
        dev_mem[32'h0304] = 32'hDEAD_BEEF;
        ref_mem[32'h0304] = 32'hDEAD_BEEF;
        run_access(0, 1'b1, 1'b0, 16'h0304, 32'h0);
        checks++;
        if (rdata_o[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_deadbeef got=%h exp=deadbeef", rdata_o[0]); end
        cyc(0);
        checks++;
        if ({o_cs, o_oe, o_wait} !== 3'b100) begin failures++; $display("FAIL after_read got={cs,oe,wait}=%b exp=100", {o_cs, o_oe, o_wait}); end
        repeat (2) cyc(0);
    endtask

    task automatic test_back_to_back;
        run_access(0, 1'b0, 1'b1, 16'h0010, 32'h1234_5678);
        run_access(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        checks++;
        if (rdata_o[0] !== 32'h1234_5678) begin failures++; $display("FAIL b2b_read got=%h exp=12345678", rdata_o[0]); end
        repeat (2) cyc(0);
    endtask

    task automatic test_rd_wr_both;
        run_access(0, 1'b1, 1'b1, 16'h0020, 32'hCAFE_F00D);
        run_access(0, 1'b1, 1'b0, 16'h0020, 32'h0);
        repeat (2) cyc(0);
    endtask

    task automatic test_reset_mid;
        addr_i[0] = 16'h0030; wd_i[0] = 32'hA1B2_C3D4; wr_i[0] = 1'b1; rd_i[0] = 1'b0;
        repeat (4) cyc(0);          // request, SETUP x2, first STROBE
        rst_n = 1'b0;
        cyc(0);                     // second STROBE cycle, reset sampled at its end
        checks++;
        if ({o_cs, o_wr, o_oe} !== 3'b001) begin failures++; $display("FAIL mid_strobe got={cs,wr,oe}=%b exp=001", {o_cs, o_wr, o_oe}); end
        cyc(0);
        checks++;
        if ({o_cs, o_wr, o_oe, o_wait} !== 4'b1100) begin failures++; $display("FAIL mid_abort got={cs,wr,oe,wait}=%b exp=1100", {o_cs, o_wr, o_oe, o_wait}); end
        checks++;
        if (rdata_o[0] !== 32'h0) begin failures++; $display("FAIL mid_rdata got=%h exp=0", rdata_o[0]); end
        rst_n = 1'b1; wr_i[0] = 1'b0;
        cyc(0);
        run_access(0, 1'b1, 1'b0, 16'h0040, 32'h0);
        repeat (2) cyc(0);
    endtask

    task automatic test_fast_cfg;
        run_access(1, 1'b0, 1'b1, 16'h0005, 32'hFFFF_A5C3);
        run_access(1, 1'b1, 1'b0, 16'h0005, 32'h0);
        checks++;
        if (first_cs !== 1'b0) begin failures++; $display("FAIL fast_cs_held1 got=%b exp=0", first_cs); end
        checks++;
        if (rdata_o[1] !== 32'h0000_A5C3) begin failures++; $display("FAIL fast_rd16 got=%h exp=0000a5c3", rdata_o[1]); end
        run_access(1, 1'b0, 1'b1, 16'h0006, 32'h0000_1234);
        checks++;
        if (first_cs !== 1'b0) begin failures++; $display("FAIL fast_cs_held2 got=%b exp=0", first_cs); end
        run_access(1, 1'b1, 1'b0, 16'h0006, 32'h0);
        checks++;
        if (first_cs !== 1'b0) begin failures++; $display("FAIL fast_cs_held3 got=%b exp=0", first_cs); end
        repeat (2) cyc(1);
    endtask

    task automatic test_random;
        int s, gap;
        bit r, w;
        for (int i = 0; i < 30; i++) begin
            s = int'($urandom_range(1, 0));
            r = 1'($urandom_range(1, 0));
            w = !r || ($urandom_range(3, 0) == 0);
            run_access(s, r, w, 16'($urandom_range(7, 0)), $urandom);
            gap = int'($urandom_range(2, 0));
            for (int g = 0; g < gap; g++) begin
                cyc(s);
                checks++;
                if (o_wait !== 1'b0) begin failures++; $display("FAIL rand_idle_wait s=%0d got=%b exp=0", s, o_wait); end
            end
        end
        repeat (3) cyc(0);
    endtask

    task automatic test_irq;
        hc_in = 1'b1; dc_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({hc_o[0], dc_o[0]} !== {k == 2, k >= 2})
                begin failures++; $display("FAIL irq k=%0d got={hc,dc}=%b exp=%b", k, {hc_o[0], dc_o[0]}, {k == 2, k >= 2}); end
            @(posedge clk); #1;
            hc_in = 1'b0;
        end
        dc_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; hc_in = 1'b0; dc_in = 1'b0;
        for (int s = 0; s < 2; s++) begin
            addr_i[s] = 16'h0; rd_i[s] = 1'b0; wr_i[s] = 1'b0; wd_i[s] = 32'h0; din[s] = 32'h0;
        end
        first_cs = 1'b1;
        test_reset();
        test_read_default();
        test_back_to_back();
        test_rd_wr_both();
        test_reset_mid();
        test_fast_cfg();
        test_random();
        test_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/isp_timed_bus_if.md
ISP_TIMED_BUS_IF -- requirements
Module: isp_timed_bus_if

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, meaning external and Avalon data width (16 or 32).
REQ-002 The block SHALL take parameter ADDR_W, default 16, meaning word address width.
REQ-003 The block SHALL take parameter T_SETUP, default 2, meaning cycles from CS_N low to strobe low (min 1).
REQ-004 The block SHALL take parameter T_STROBE, default 4, meaning cycles RD_N/WR_N held low (min 1).
REQ-005 The block SHALL take parameter T_HOLD, default 2, meaning cycles from strobe high to CS_N high (min 1).
REQ-006 The block SHALL take parameter T_TURN, default 1, meaning idle cycles with CS_N high between accesses (min 0).
REQ-007 The block SHALL provide port csi_clk, input, 1, the single clock.
REQ-008 The block SHALL provide port csi_reset_n, input, 1, reset that is synchronous and active-low.
REQ-009 The block SHALL provide ports avs_address in ADDR_W, avs_read in 1, avs_write in 1, avs_writedata in DATA_W, avs_readdata out DATA_W and avs_waitrequest out 1, forming the Avalon-MM slave.
REQ-010 The block SHALL provide ports ins_hc_irq out 1 and ins_dc_irq out 1, the synchronised interrupts.
REQ-011 The block SHALL provide ports CS_N out 1, RD_N out 1, WR_N out 1 and A out ADDR_W+1, where A equals {address,1'b0}.
REQ-012 The block SHALL provide ports D_IN in DATA_W, D_OUT out DATA_W and D_OE out 1; the top level builds the tristate as D = D_OE ? D_OUT : Z.
REQ-013 The block SHALL provide ports HC_IRQ in 1, DC_IRQ in 1, and DC_DACK out 1 and HC_DACK out 1, with both DACK outputs tied inactive high.

Function
REQ-014 The FSM SHALL have the states IDLE, SETUP, STROBE, HOLD and TURN, with a single down-counter sized for the largest T_* value.
REQ-015 In IDLE with avs_read or avs_write high, the block SHALL latch address, direction and writedata, enter SETUP on the next edge, and drive CS_N low from that cycle.
REQ-016 In SETUP, A SHALL be driven, RD_N and WR_N SHALL be high, and the FSM SHALL advance to STROBE after exactly T_SETUP cycles.
REQ-017 In STROBE, RD_N (read) or WR_N (write) SHALL be low for exactly T_STROBE cycles, then the FSM SHALL enter HOLD.
REQ-018 On a read, D_IN SHALL be registered into avs_readdata at the clock edge that ends the last STROBE cycle.
REQ-019 On a write, D_OE SHALL be 1 and D_OUT SHALL equal the latched writedata throughout SETUP, STROBE and HOLD; D_OE SHALL be 0 in every other state and for every read.
REQ-020 In HOLD, CS_N SHALL stay low and both strobes high; avs_waitrequest SHALL be 0 only in the last HOLD cycle, so completion comes T_SETUP+T_STROBE+T_HOLD cycles after the request is first seen.
REQ-021 avs_waitrequest SHALL be 1 in all other cycles in which avs_read or avs_write is high, and 0 when the slave is idle with no request.
REQ-022 After HOLD, the FSM SHALL enter TURN for T_TURN cycles with CS_N high, or go straight to IDLE when T_TURN=0; a request pending during TURN SHALL be held off with waitrequest 1.
REQ-023 If avs_read and avs_write are both high, the block SHALL perform a read and ignore the write.
REQ-024 If the master drops its request mid-access, the access SHALL still complete with full timing, and nothing is returned.
REQ-025 HC_IRQ and DC_IRQ SHALL each pass through a 2-flop synchroniser; irq latency SHALL be 2 cycles.
REQ-026 avs_readdata SHALL hold its last value until the next read capture.

Reset
REQ-027 When csi_reset_n=0 at an edge, the block SHALL set the state to IDLE, CS_N=RD_N=WR_N=1, D_OE=0, avs_waitrequest=0, avs_readdata=0, irq outputs and synchronisers=0 and the counter=0.
REQ-028 Reset asserted mid-access SHALL abort the access at the next edge with no completion pulse, and the first post-reset request SHALL start cleanly from IDLE.

Verification
REQ-029 The bench SHALL cover a default-parameter read at addr 0x0304 with D_IN=0xDEADBEEF: A=0x0608, CS_N low 8 cycles, RD_N low cycles 3-6, waitrequest low in cycle 8, readdata=0xDEADBEEF, D_OE=0 throughout.
REQ-030 The bench SHALL cover a write of 0x12345678 followed back-to-back by a read: D_OE=1 for exactly 8 cycles, WR_N low 4, then 1 TURN cycle with CS_N high before the read's SETUP.
REQ-031 The bench SHALL cover T_SETUP=T_STROBE=T_HOLD=1 and T_TURN=0 with DATA_W=16: 3-cycle access, back-to-back accesses with CS_N held low, and 16-bit data correct.
REQ-032 The bench SHALL cover read and write asserted together: only RD_N pulses, WR_N stays 1 and D_OE stays 0.
REQ-033 The bench SHALL cover reset asserted in the second STROBE cycle of a write: next edge CS_N=WR_N=1, D_OE=0, waitrequest=0, and the following read completes normally.
REQ-034 The bench SHALL cover an HC_IRQ pulse of 1 cycle: ins_hc_irq high for exactly 1 cycle, 2 cycles later; and DC_IRQ held high: ins_dc_irq high after 2 cycles.
